// File: rtl/opamp_sched_pkg.sv
// Shared types, widths and defaults for the op-amp buffer channel scheduler.
package opamp_sched_pkg;

  localparam int unsigned N_REQ          = 4;
  localparam int unsigned IDX_W          = 2;
  localparam int unsigned CNT_W          = 8;
  localparam int unsigned SETTLE_CYC_DEF = 8;
  localparam int unsigned DISCH_CYC_DEF  = 4;

  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_SETTLE = 2'd1,
    CH_ACTIVE = 2'd2,
    CH_DISCH  = 2'd3
  } ch_state_e;

  // Next-cycle view of one channel's contribution to the top-level outputs.
  typedef struct packed {
    logic             en;
    logic [IDX_W-1:0] sel;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] rdy;
  } ch_out_t;

  // One-hot decode of a requester index.
  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

  // Round-robin successor of a requester index (wraps at N_REQ).
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
    return IDX_W'(idx + IDX_W'(1));
  endfunction

endpackage

// File: rtl/opamp_chan_fsm.sv
// One buffer channel: IDLE -> SETTLE -> ACTIVE -> DISCH -> IDLE with a down-counter.
module opamp_chan_fsm
  import opamp_sched_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int unsigned DISCH_CYC  = DISCH_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             assign_vld,
  input  logic [IDX_W-1:0] assign_idx,
  output logic             idle_c,
  output logic [N_REQ-1:0] held_c,
  output ch_out_t          nxt_c
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DISCH_LOAD  = CNT_W'(DISCH_CYC - 1);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             owner_req;

  assign owner_req = req[idx_q];
  assign idle_c    = (state_q == CH_IDLE);
  assign held_c    = ((state_q == CH_SETTLE) || (state_q == CH_ACTIVE)) ? onehot(idx_q) : '0;

  // State, counter and owner index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CH_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next state plus the next-cycle output view the top registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    nxt_c   = '0;

    case (state_q)
      CH_IDLE: begin
        if (assign_vld) begin
          state_d = CH_SETTLE;
          cnt_d   = SETTLE_LOAD;
          idx_d   = assign_idx;
        end
      end
      CH_SETTLE: begin
        if (!owner_req) begin
          state_d = CH_DISCH;
          cnt_d   = DISCH_LOAD;
        end else if (cnt_q == '0) begin
          state_d = CH_ACTIVE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CH_ACTIVE: begin
        if (!owner_req) begin
          state_d = CH_DISCH;
          cnt_d   = DISCH_LOAD;
        end
      end
      CH_DISCH: begin
        if (cnt_q == '0) begin
          state_d = CH_IDLE;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = CH_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    if ((state_d == CH_SETTLE) || (state_d == CH_ACTIVE)) begin
      nxt_c.en  = 1'b1;
      nxt_c.sel = idx_d;
      nxt_c.gnt = onehot(idx_d);
    end
    if (state_d == CH_ACTIVE) begin
      nxt_c.rdy = onehot(idx_d);
    end
  end

endmodule

// File: rtl/opamp_chan_sched.sv
// Two-channel op-amp buffer scheduler: round-robin arbiter over four requesters.
module opamp_chan_sched
  import opamp_sched_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int unsigned DISCH_CYC  = DISCH_CYC_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_REQ-1:0] REQ,
  output logic [N_REQ-1:0] GNT,
  output logic [N_REQ-1:0] RDY,
  output logic             EN1,
  output logic             EN2,
  output logic [IDX_W-1:0] SEL1,
  output logic [IDX_W-1:0] SEL2
);

  logic [IDX_W-1:0] rr_q, rr_d;
  logic [N_REQ-1:0] elig_c;
  logic [IDX_W-1:0] cand_c;
  logic             first_vld_c, second_vld_c;
  logic [IDX_W-1:0] first_idx_c, second_idx_c;
  logic             a1_vld_c, a2_vld_c;
  logic [IDX_W-1:0] a1_idx_c, a2_idx_c;
  logic             idle1_c, idle2_c;
  logic [N_REQ-1:0] held1_c, held2_c;
  ch_out_t          nxt1_c, nxt2_c;

  // A requester already owning a settling/active channel is not eligible again.
  assign elig_c = REQ & ~(held1_c | held2_c);

  // First and second eligible requesters scanning from the round-robin pointer.
  always_comb begin
    first_vld_c  = 1'b0;
    second_vld_c = 1'b0;
    first_idx_c  = '0;
    second_idx_c = '0;
    cand_c       = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand_c = IDX_W'(rr_q + IDX_W'(i));
      if (elig_c[cand_c]) begin
        if (!first_vld_c) begin
          first_vld_c = 1'b1;
          first_idx_c = cand_c;
        end else if (!second_vld_c) begin
          second_vld_c = 1'b1;
          second_idx_c = cand_c;
        end
      end
    end
  end

  // Lowest idle channel takes the first pick; pointer follows the last grant.
  always_comb begin
    a1_vld_c = idle1_c && first_vld_c;
    a1_idx_c = first_idx_c;
    a2_vld_c = idle2_c && (idle1_c ? second_vld_c : first_vld_c);
    a2_idx_c = idle1_c ? second_idx_c : first_idx_c;
    rr_d     = rr_q;
    if (a2_vld_c) begin
      rr_d = rr_next(a2_idx_c);
    end else if (a1_vld_c) begin
      rr_d = rr_next(a1_idx_c);
    end
  end

  // Round-robin pointer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

  opamp_chan_fsm #(
    .SETTLE_CYC (SETTLE_CYC),
    .DISCH_CYC  (DISCH_CYC)
  ) u_ch1 (
    .clk        (CLK),
    .rst        (RST),
    .req        (REQ),
    .assign_vld (a1_vld_c),
    .assign_idx (a1_idx_c),
    .idle_c     (idle1_c),
    .held_c     (held1_c),
    .nxt_c      (nxt1_c)
  );

  opamp_chan_fsm #(
    .SETTLE_CYC (SETTLE_CYC),
    .DISCH_CYC  (DISCH_CYC)
  ) u_ch2 (
    .clk        (CLK),
    .rst        (RST),
    .req        (REQ),
    .assign_vld (a2_vld_c),
    .assign_idx (a2_idx_c),
    .idle_c     (idle2_c),
    .held_c     (held2_c),
    .nxt_c      (nxt2_c)
  );

  // Output registers, aligned with the channel state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      GNT  <= '0;
      RDY  <= '0;
      EN1  <= 1'b0;
      EN2  <= 1'b0;
      SEL1 <= '0;
      SEL2 <= '0;
    end else begin
      GNT  <= nxt1_c.gnt | nxt2_c.gnt;
      RDY  <= nxt1_c.rdy | nxt2_c.rdy;
      EN1  <= nxt1_c.en;
      EN2  <= nxt2_c.en;
      SEL1 <= nxt1_c.sel;
      SEL2 <= nxt2_c.sel;
    end
  end

endmodule
